// File: rtl/crc16_check.sv
// Receive-side USB CRC16 checker: accumulates data field plus received CRC and compares against the residual.
// Optional saturating error counter output err_cnt enabled by defining CRC16_CHECK_STATS_EN.
module crc16_check #(
    parameter logic [15:0] POLY     = 16'h8005,
    parameter logic [15:0] INIT     = 16'hFFFF,
    parameter logic [15:0] RESIDUAL = 16'h800D,
    parameter int          MAX_BITS = 8208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_in,
    input  logic       bit_valid,
    input  logic       pkt_start,
    input  logic       pkt_end,
    input  logic       chk_ack,
    output logic       chk_ready,
    output logic       chk_done,
    output logic       crc_ok,
    output logic       crc_err,
    output logic       len_err
`ifdef CRC16_CHECK_STATS_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    // state | meaning
    // IDLE  | waiting for pkt_start, chk_ready=1
    // RUN   | shifting valid bits of the current field
    // DONE  | result flags held until chk_ack
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Counter saturates one past MAX_BITS so over-length fields stay detectable.
    localparam int            CW      = $clog2(MAX_BITS + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BITS);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_BITS + 1);
    localparam logic [CW-1:0] CNT_MIN = CW'(16);

    state_t        state, state_nxt;
    logic [15:0]   r, r_nxt, r_fresh, r_run;
    logic [CW-1:0] cnt, cnt_nxt, cnt_fresh, cnt_run;
    logic          ok_q, crc_err_q, len_err_q;
    logic          ok_nxt, crc_err_nxt, len_err_nxt;
    logic          len_bad, crc_bad;

    function automatic logic [15:0] crc_step(input logic [15:0] cur, input logic b);
        crc_step = {cur[14:0], 1'b0} ^ ((b ^ cur[15]) ? POLY : 16'h0000);
    endfunction

    always_comb begin
        r_fresh   = bit_valid ? crc_step(INIT, s_in) : INIT;
        cnt_fresh = bit_valid ? CW'(1) : '0;
        r_run     = bit_valid ? crc_step(r, s_in) : r;
        cnt_run   = (bit_valid && (cnt != CNT_SAT)) ? cnt + 1'b1 : cnt;
        len_bad   = (cnt_run < CNT_MIN) || (cnt_run[2:0] != 3'd0) || (cnt_run > CNT_MAX);
        crc_bad   = (r_run != RESIDUAL);
    end

    always_comb begin
        state_nxt   = state;
        r_nxt       = r;
        cnt_nxt     = cnt;
        ok_nxt      = ok_q;
        crc_err_nxt = crc_err_q;
        len_err_nxt = len_err_q;
        case (state)
            IDLE: begin
                if (pkt_start) begin
                    state_nxt = RUN;
                    r_nxt     = r_fresh;
                    cnt_nxt   = cnt_fresh;
                end
            end
            RUN: begin
                if (pkt_start) begin
                    r_nxt   = r_fresh;
                    cnt_nxt = cnt_fresh;
                end else begin
                    r_nxt   = r_run;
                    cnt_nxt = cnt_run;
                    if (pkt_end) begin
                        state_nxt   = DONE;
                        len_err_nxt = len_bad;
                        crc_err_nxt = crc_bad;
                        ok_nxt      = !len_bad && !crc_bad;
                    end
                end
            end
            DONE: begin
                if (chk_ack) begin
                    ok_nxt      = 1'b0;
                    crc_err_nxt = 1'b0;
                    len_err_nxt = 1'b0;
                    if (pkt_start) begin
                        state_nxt = RUN;
                        r_nxt     = r_fresh;
                        cnt_nxt   = cnt_fresh;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            r         <= INIT;
            cnt       <= '0;
            ok_q      <= 1'b0;
            crc_err_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            r         <= r_nxt;
            cnt       <= cnt_nxt;
            ok_q      <= ok_nxt;
            crc_err_q <= crc_err_nxt;
            len_err_q <= len_err_nxt;
        end
    end

    assign chk_ready = (state == IDLE);
    assign chk_done  = (state == DONE);
    assign crc_ok    = ok_q;
    assign crc_err   = crc_err_q;
    assign len_err   = len_err_q;

`ifdef CRC16_CHECK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if ((state == RUN) && (state_nxt == DONE) && !ok_nxt && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_crc16_check.sv
// Self-checking bench for crc16_check: directed cases plus random packets against a polynomial-division model.
module tb_crc16_check;

    localparam logic [15:0] POLY     = 16'h8005;
    localparam logic [15:0] INIT     = 16'hFFFF;
    localparam logic [15:0] RESIDUAL = 16'h800D;
    localparam int          MAX_BITS = 8208;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_in = 1'b0, bit_valid = 1'b0, pkt_start = 1'b0, pkt_end = 1'b0, chk_ack = 1'b0;
    logic chk_ready, chk_done, crc_ok, crc_err, len_err;
`ifdef CRC16_CHECK_STATS_EN
    logic [7:0] err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_err  = 0;

    crc16_check dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_in      (s_in),
        .bit_valid (bit_valid),
        .pkt_start (pkt_start),
        .pkt_end   (pkt_end),
        .chk_ack   (chk_ack),
        .chk_ready (chk_ready),
        .chk_done  (chk_done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .len_err   (len_err)
`ifdef CRC16_CHECK_STATS_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Remainder of (INIT*x^n + M(x)*x^16) mod P by long division over a bit array.
    function automatic logic [15:0] remainder(input bit q[$]);
        int          n = q.size();
        bit          a[];
        logic [16:0] g;
        logic [15:0] init_v;
        logic [15:0] rem;
        g      = {1'b1, POLY};
        init_v = INIT;
        a      = new[n + 16];
        for (int i = 0; i < n + 16; i++) a[i] = (i < n) ? q[i] : 1'b0;
        for (int i = 0; i < 16; i++) a[i] ^= init_v[15 - i];
        for (int i = 0; i < n; i++)
            if (a[i])
                for (int j = 0; j <= 16; j++) a[i + j] ^= g[16 - j];
        for (int i = 0; i < 16; i++) rem[15 - i] = a[n + i];
        return rem;
    endfunction

    task automatic append_good_crc(inout bit q[$]);
        logic [15:0] c;
        c = ~remainder(q);
        for (int i = 15; i >= 0; i--) q.push_back(c[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_in = 1'b0; bit_valid = 1'b0; pkt_start = 1'b0; pkt_end = 1'b0; chk_ack = 1'b0;
    endtask

    // gap_mode: 0 contiguous, 1 alternate idle cycles, 2 random idle cycles
    task automatic run_pkt(input bit q[$], input int gap_mode, input bit start_bit,
                           input bit end_on_bit, input bit with_ack);
        int k = 0;
        pkt_start = 1'b1;
        chk_ack   = with_ack;
        if (start_bit && q.size() > 0) begin
            s_in = q[0]; bit_valid = 1'b1; k = 1;
        end
        tick();
        clear_inputs();
        check_val("run_ready", chk_ready, 0);
        for (int i = k; i < q.size(); i++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                s_in = $urandom_range(0, 1);
                tick();
            end
            s_in = q[i]; bit_valid = 1'b1;
            pkt_end = end_on_bit && (i == q.size() - 1);
            tick();
            clear_inputs();
        end
        if (!end_on_bit || q.size() == 0) begin
            pkt_end = 1'b1;
            tick();
            clear_inputs();
        end
    endtask

    task automatic check_result(input string tag, input bit q[$], input bit do_ack);
        bit          len_e, crc_e, ok;
        int          n = q.size();
        len_e = (n < 16) || (n % 8 != 0) || (n > MAX_BITS);
        crc_e = (remainder(q) != RESIDUAL);
        ok    = !len_e && !crc_e;
        if (!ok && exp_err < 255) exp_err++;
        for (int rep = 0; rep < 2; rep++) begin
            check_val({tag, "_done"}, chk_done, 1);
            check_val({tag, "_ready"}, chk_ready, 0);
            check_val({tag, "_ok"}, crc_ok, ok);
            check_val({tag, "_crc_err"}, crc_err, crc_e);
            check_val({tag, "_len_err"}, len_err, len_e);
`ifdef CRC16_CHECK_STATS_EN
            check_val({tag, "_err_cnt"}, err_cnt, exp_err);
`endif
            if (rep == 0) begin
                // Unacked traffic in DONE must not disturb the held result.
                pkt_start = 1'b1; bit_valid = 1'b1; s_in = 1'b1; pkt_end = 1'b1;
                tick();
                clear_inputs();
                tick();
            end
        end
        if (do_ack) begin
            chk_ack = 1'b1;
            tick();
            clear_inputs();
            check_val({tag, "_ack_ready"}, chk_ready, 1);
            check_val({tag, "_ack_done"}, chk_done, 0);
            check_val({tag, "_ack_flags"}, {crc_ok, crc_err, len_err}, 0);
        end
    endtask

    initial begin
        bit z16[$], q[$];
        for (int i = 0; i < 16; i++) z16.push_back(1'b0);

        clear_inputs();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check_val("rst_ready", chk_ready, 1);
        check_val("rst_done", chk_done, 0);
        check_val("rst_flags", {crc_ok, crc_err, len_err}, 0);
`ifdef CRC16_CHECK_STATS_EN
        check_val("rst_err_cnt", err_cnt, 0);
`endif

        pkt_end = 1'b1; tick(); clear_inputs();
        check_val("idle_end_ignored", chk_ready, 1);

        run_pkt(z16, 0, 0, 0, 0); check_result("zero_len", z16, 1);
        q = z16; q[0] = 1'b1;
        run_pkt(q, 0, 0, 0, 0); check_result("corrupt", q, 1);
        run_pkt(z16, 1, 0, 0, 0); check_result("gapped", z16, 1);
        q = {}; for (int i = 0; i < 8; i++) q.push_back(1'b0);
        run_pkt(q, 0, 0, 1, 0); check_result("len8", q, 1);
        q = {}; for (int i = 0; i < 20; i++) q.push_back(1'b0);
        run_pkt(q, 0, 1, 1, 0); check_result("len20", q, 1);

        pkt_start = 1'b1; tick(); clear_inputs();
        for (int i = 0; i < 10; i++) begin s_in = 1'b1; bit_valid = 1'b1; tick(); clear_inputs(); end
        run_pkt(z16, 0, 0, 0, 0); check_result("abort", z16, 0);
        run_pkt(z16, 0, 0, 0, 1); check_result("ack_start", z16, 1);

        pkt_start = 1'b1; tick(); clear_inputs();
        for (int i = 0; i < 5; i++) begin s_in = 1'b1; bit_valid = 1'b1; tick(); clear_inputs(); end
        #2 rst_n = 1'b0;
        #1;
        exp_err = 0;
        check_val("midrst_ready", chk_ready, 1);
        check_val("midrst_done", chk_done, 0);
        check_val("midrst_flags", {crc_ok, crc_err, len_err}, 0);
`ifdef CRC16_CHECK_STATS_EN
        check_val("midrst_err_cnt", err_cnt, 0);
`endif
        @(negedge clk); rst_n = 1'b1;
        tick();
        run_pkt(z16, 0, 0, 0, 0); check_result("post_rst", z16, 1);

        for (int p = 0; p < 30; p++) begin
            int nbytes = $urandom_range(0, 4);
            int mode   = $urandom_range(0, 3);
            q = {};
            for (int i = 0; i < nbytes * 8; i++) q.push_back($urandom_range(0, 1));
            append_good_crc(q);
            if (mode == 1) begin
                int idx = $urandom_range(0, q.size() - 1);
                q[idx] = ~q[idx];
            end else if (mode == 2) begin
                int drop = $urandom_range(1, 7);
                for (int i = 0; i < drop; i++) void'(q.pop_back());
            end
            run_pkt(q, $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 1), 0);
            check_result("rand", q, 1);
        end

        q = {};
        for (int i = 0; i < (MAX_BITS - 16); i++) q.push_back($urandom_range(0, 1));
        append_good_crc(q);
        run_pkt(q, 0, 0, 1, 0); check_result("max_len", q, 1);
        q = {};
        for (int i = 0; i < (MAX_BITS - 8); i++) q.push_back($urandom_range(0, 1));
        append_good_crc(q);
        run_pkt(q, 0, 0, 0, 0); check_result("over_len", q, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
